// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   The 16-bit packed digit word is snapshotted once per scan frame, so a
//   change to data partway through a frame is never shown. Each digit slot
//   opens with a short gap where all anodes are off, which stops ghosting.
//   All outputs are registered, so they lag the scan state by one clock.
//
// Parameters
//   REFRESH_DIV  clk cycles per digit slot (>= BLANK_CYC+2)
//   BLANK_CYC    cycles at the start of each slot with all anodes off (>= 1)
//   BLINK_DIV    frames per blink half-period (blink builds only)
//
// Ports
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high
//   data         in   16  digits: [15:12] leftmost .. [3:0] rightmost
//   blink        in   1   blink request (blink builds only)
//   an           out  4   anodes, active-low, an[3] = leftmost digit
//   seg          out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp           out  1   decimal point, active-low, always off
//   frame_start  out  1   one-cycle pulse when a new snapshot takes effect
//
// Optional feature: define SEG7_BLINK_EN to build the blink logic.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter int unsigned BLINK_DIV   = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_t;

  logic [CW-1:0] cnt;
  slot_t         idx;
  logic [15:0]   frame;
  logic          tick;
  logic          wrap;
  logic          blank;
  logic          suppress;
  logic [3:0]    nib;
  logic [3:0]    an_sel;
  slot_t         idx_next;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b1111111;  // 4'hF is the blank code
    endcase
    return s;
  endfunction

  assign tick  = (cnt == CW'(REFRESH_DIV - 1));
  assign wrap  = tick && (idx == SLOT3);
  assign blank = (cnt < CW'(BLANK_CYC));

  always_comb begin
    nib      = frame[15:12];
    an_sel   = 4'b0111;
    idx_next = SLOT1;
    case (idx)
      SLOT0: begin nib = frame[15:12]; an_sel = 4'b0111; idx_next = SLOT1; end
      SLOT1: begin nib = frame[11:8];  an_sel = 4'b1011; idx_next = SLOT2; end
      SLOT2: begin nib = frame[7:4];   an_sel = 4'b1101; idx_next = SLOT3; end
      SLOT3: begin nib = frame[3:0];   an_sel = 4'b1110; idx_next = SLOT0; end
      default: ;
    endcase
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FW-1:0] fcnt;
  logic          phase;
  logic          blink_q;

  // blink is captured with the frame snapshot so suppression only ever
  // starts or stops on a frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt    <= '0;
      phase   <= 1'b0;
      blink_q <= 1'b0;
    end else if (wrap) begin
      blink_q <= blink;
      if (fcnt == FW'(BLINK_DIV - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign suppress = blink_q && phase;
`else
  localparam int unsigned UNUSED_BLINK_DIV = BLINK_DIV;
  logic unused_blink;
  assign unused_blink = blink;
  assign suppress     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= SLOT0;
      frame       <= 16'hFFFF;
      an          <= 4'b1111;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx_next;
      if (wrap) frame <= data;
      frame_start <= wrap;
      an          <= (blank || suppress) ? 4'b1111 : an_sel;
      seg         <= decode(nib);
      dp          <= 1'b1;
    end
  end

endmodule
